// File: rtl/karatsuba_mult_scheduler_pkg.sv
// karatsuba_mult_scheduler_pkg: shared state encoding, datapath widths and clog2 helper
package karatsuba_mult_scheduler_pkg;
   localparam int OP_W   = 32;
   localparam int PROD_W = 64;
   typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, RUN = 2'd2, RESP = 2'd3} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin pick, first request scanning upward from ptr+1
module rr_arbiter_n
   import karatsuba_mult_scheduler_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] idx
);
   logic            found;
   logic [ID_W-1:0] k;
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k = ID_W'((int'(ptr) + i) % NREQ);
         if (!found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end
endmodule

// File: rtl/karatsuba_mult_scheduler.sv
// karatsuba_mult_scheduler: round-robin sharing of one iterative multiply engine with watchdog
module karatsuba_mult_scheduler
   import karatsuba_mult_scheduler_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [OP_W*NREQ-1:0] req_a,
   input  logic [OP_W*NREQ-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [PROD_W-1:0]    rsp_data,
   output logic                 rsp_err,
   output logic                 eng_rst,
   output logic                 eng_en,
   output logic [OP_W-1:0]      eng_a,
   output logic [OP_W-1:0]      eng_b,
   input  logic                 eng_done,
   input  logic [PROD_W-1:0]    eng_c
);
   state_t              state, state_nx;
   logic [ID_W-1:0]     rr_ptr, id_q, win_idx;
   logic [NREQ-1:0]     grant;
   logic [OP_W-1:0]     a_q, b_q, a_sel, b_sel;
   logic [PROD_W-1:0]   data_q;
   logic                err_q, expire;
   logic [7:0]          cnt;

   rr_arbiter_n #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx)
   );

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            a_sel = req_a[i*OP_W +: OP_W];
            b_sel = req_b[i*OP_W +: OP_W];
         end
      end
   end

   assign expire = cnt == 8'(TIMEOUT - 1);

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      eng_rst   = rst | (state == CLR);
      eng_en    = state == RUN;
      rsp_valid = state == RESP;
      case (state)
         IDLE: begin
            req_ready = grant;
            state_nx  = |grant ? CLR : IDLE;
         end
         CLR:     state_nx = RUN;
         RUN:     state_nx = (eng_done || expire) ? RESP : RUN;
         RESP:    state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= ID_W'(NREQ - 1);
         a_q    <= '0;
         b_q    <= '0;
         id_q   <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && |grant) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            id_q   <= win_idx;
            rr_ptr <= win_idx;
         end
         if (state == CLR) cnt <= '0;
         // done takes priority over watchdog expiry in the same cycle
         if (state == RUN) begin
            cnt <= cnt + 8'd1;
            if (eng_done) begin
               data_q <= eng_c;
               err_q  <= 1'b0;
            end else if (expire) begin
               data_q <= '0;
               err_q  <= 1'b1;
            end
         end
      end
   end

   assign eng_a    = a_q;
   assign eng_b    = b_q;
   assign rsp_id   = id_q;
   assign rsp_data = data_q;
   assign rsp_err  = err_q;
endmodule

// File: tb/tb_karatsuba_mult_scheduler.sv
// tb_karatsuba_mult_scheduler: randomized scoreboard bench with engine model and round-robin reference
module tb_karatsuba_mult_scheduler;
   localparam int NREQ    = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 15;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] data;
      logic        err;
      int          runs;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a, req_b;
   logic                 rsp_valid, rsp_ready, rsp_err;
   logic [ID_W-1:0]      rsp_id;
   logic [63:0]          rsp_data;
   logic                 eng_rst, eng_en, eng_done;
   logic [31:0]          eng_a, eng_b;
   logic [63:0]          eng_c;

   logic [31:0] a_arr [NREQ];
   logic [31:0] b_arr [NREQ];
   logic [NREQ-1:0] keep;
   int acc_cnt [NREQ];
   int seen [NREQ];
   int eng_l, ecnt;
   logic stuck, rnd_ready;

   exp_t q[$];
   exp_t e;
   int checks = 0, fails = 0;
   int ptr_m, w, k, lat, en_n, clr_n;
   logic busy, held, op_bad;
   logic [63:0] snap_d;
   logic [ID_W:0] snap_t;

   always #5 clk = ~clk;

   karatsuba_mult_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .eng_rst   (eng_rst),
      .eng_en    (eng_en),
      .eng_a     (eng_a),
      .eng_b     (eng_b),
      .eng_done  (eng_done),
      .eng_c     (eng_c)
   );

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*32 +: 32] = a_arr[i];
         req_b[i*32 +: 32] = b_arr[i];
      end
   end

   // engine: done after eng_l enabled cycles, sticky until cleared; garbage product before done
   always @(posedge clk) begin
      if (eng_rst) ecnt <= 0;
      else if (eng_en && ecnt < 1000) ecnt <= ecnt + 1;
   end
   assign eng_done = !stuck && ecnt >= eng_l;
   assign eng_c    = eng_done ? {32'b0, eng_a} * {32'b0, eng_b} : 64'hDEAD_BEEF_0BAD_F00D;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_eng_rst", 64'(eng_rst), 64'd1);
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_eng_en", 64'(eng_en), 64'd0);
         chk("rst_rsp_fields", {rsp_data[31:0], 29'(rsp_id), rsp_err, rsp_data[63:62]}, 64'd0);
         chk("rst_eng_ab", {eng_a, eng_b}, 64'd0);
         q.delete();
         busy  = 1'b0;
         held  = 1'b0;
         ptr_m = NREQ - 1;
      end else begin
         w = -1;
         if (!busy)
            for (int j = 1; j <= NREQ; j++) begin
               k = (ptr_m + j) % NREQ;
               if (w < 0 && req_valid[k]) w = k;
            end
         chk("req_ready", 64'(req_ready), w < 0 ? 64'd0 : 64'd1 << w);
         if (w >= 0) begin
            e.id   = w;
            e.a    = a_arr[w];
            e.b    = b_arr[w];
            e.err  = stuck || (eng_l + 1 > TIMEOUT);
            e.runs = e.err ? TIMEOUT : eng_l + 1;
            e.data = e.err ? 64'd0 : 64'(e.a) * 64'(e.b);
            q.push_back(e);
            ptr_m = w;
            acc_cnt[w]++;
            busy   = 1'b1;
            lat    = 0;
            en_n   = 0;
            clr_n  = 0;
            op_bad = 1'b0;
         end else if (busy) begin
            lat++;
            if (eng_rst) clr_n++;
            if (eng_en) en_n++;
            if ((eng_rst || eng_en) && q.size() > 0 && (eng_a !== q[0].a || eng_b !== q[0].b)) op_bad = 1'b1;
         end
         if (rsp_valid) begin
            chk("rsp_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               if (!held) chk("rsp_latency", 64'(lat), 64'(q[0].runs + 2));
               else begin
                  chk("rsp_stable_data", rsp_data, snap_d);
                  chk("rsp_stable_tag", 64'({rsp_id, rsp_err}), 64'(snap_t));
               end
               snap_d = rsp_data;
               snap_t = {rsp_id, rsp_err};
               if (rsp_ready) begin
                  chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                  chk("rsp_data", rsp_data, q[0].data);
                  chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
                  chk("run_cycles", 64'(en_n), 64'(q[0].runs));
                  chk("clr_pulses", 64'(clr_n), 64'd1);
                  chk("eng_operands", 64'(op_bad), 64'd0);
                  void'(q.pop_front());
                  busy = 1'b0;
               end
            end
         end
         held = rsp_valid && !rsp_ready;
      end
   end

   function automatic int total();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += acc_cnt[i];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (seen[i] != acc_cnt[i]) begin
            seen[i] = acc_cnt[i];
            if (keep[i]) begin
               a_arr[i] = $urandom;
               b_arr[i] = $urandom;
            end else req_valid[i] = 1'b0;
         end
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic request(input int i, input logic [31:0] a, input logic [31:0] b);
      a_arr[i]     = a;
      b_arr[i]     = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic bound_fail(input string name);
      $display("FAIL %s: wait bound expired at %0t", name, $time);
      $fatal(1, "bench stopped");
   endtask

   task automatic wait_done();
      int n = 0;
      while ((req_valid != 0 || q.size() != 0 || busy) && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) bound_fail("wait_done");
   endtask

   task automatic do_reset();
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int n, m, base;
      rst = 1'b1; rsp_ready = 1'b1; req_valid = '0; keep = '0;
      eng_l = 5; stuck = 1'b0; rnd_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = '0; b_arr[i] = '0; acc_cnt[i] = 0; seen[i] = 0;
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();
      request(2, 32'h0001_0002, 32'h0003_0004);
      wait_done();
      do_reset();
      keep = '1;
      for (int i = 0; i < NREQ; i++) request(i, $urandom, $urandom);
      base = total();
      n = 0;
      while (total() < base + 5 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) bound_fail("all_four");
      keep = '0;
      req_valid = '0;
      wait_done();
      rsp_ready = 1'b0;
      request(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      request(3, $urandom, $urandom);
      n = 0;
      while (!rsp_valid && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) bound_fail("backpressure");
      repeat (10) tick();
      rsp_ready = 1'b1;
      wait_done();
      stuck = 1'b1;
      request(0, $urandom, $urandom);
      wait_done();
      stuck = 1'b0;
      request(1, $urandom, $urandom);
      wait_done();
      eng_l = 14;
      request(2, $urandom, $urandom);
      wait_done();
      eng_l = 15;
      request(3, $urandom, $urandom);
      wait_done();
      rnd_ready = 1'b1;
      repeat (40) begin
         eng_l = $urandom_range(1, 16);
         m = $urandom_range(1, 15);
         for (int i = 0; i < NREQ; i++) if (m[i]) request(i, $urandom, $urandom);
         wait_done();
      end
      rnd_ready = 1'b0;
      rsp_ready = 1'b1;
      eng_l = 5;
      request(2, $urandom, $urandom);
      n = 0;
      while (!eng_en && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) bound_fail("mid_run");
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      request(1, $urandom, $urandom);
      request(0, $urandom, $urandom);
      wait_done();
      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
